// File: rtl/code_lock_param.sv
// Keypad code lock: digit entry, open timer, passcode programming and,
// when LOCK_LOCKOUT_EN is defined, a lockout after MAX_TRIES wrong codes.
module code_lock_param #(
   parameter int CODE_LEN       = 4,
   parameter int OPEN_CYCLES    = 5,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       unlock,
   output logic       lockout,
   output logic [2:0] fail_cnt,
   output logic [2:0] state
);
   localparam int W = CODE_LEN * 4;
   localparam logic [3:0]  LAST_IDX  = 4'(CODE_LEN - 1);
   localparam logic [15:0] OPEN_LOAD = 16'(OPEN_CYCLES);
`ifdef LOCK_LOCKOUT_EN
   localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYCLES);
   localparam logic [2:0]  FAIL_SAT  = 3'(MAX_TRIES);
`else
   localparam logic [2:0]  FAIL_SAT  = 3'd7;
`endif

   if (CODE_LEN < 1 || CODE_LEN > 8 || OPEN_CYCLES < 1 || OPEN_CYCLES > 255 ||
       MAX_TRIES < 1 || MAX_TRIES > 7 || LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535) begin : g_param_check
      $error("code_lock_param: parameter out of legal range");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_OPEN    = 3'd2,
      S_PROG    = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [W-1:0] code_q, code_d;
   logic [W-1:0] entry_q, entry_d, entry_next;
   logic [W-1:0] shadow_q, shadow_d, shadow_next;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] timer_q, timer_d;
   logic [2:0]  fail_q, fail_d, fail_inc;
   logic        unlock_q;
   logic        key_in, is_digit, is_cancel, is_set, last_digit;

   assign key_in      = ena & key_valid;
   assign is_digit    = key_in && (key_code <= 4'd9);
   assign is_cancel   = key_in && (key_code == 4'hD);
   assign is_set      = key_in && (key_code == 4'hE);
   assign last_digit  = (cnt_q == LAST_IDX);
   // Newest digit lands in the low nibble; the first digit ends up on top.
   assign entry_next  = (entry_q << 4) | W'(key_code);
   assign shadow_next = (shadow_q << 4) | W'(key_code);
   assign fail_inc    = (fail_q == FAIL_SAT) ? fail_q : fail_q + 3'd1;

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      entry_d  = entry_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      fail_d   = fail_q;
      case (state_q)
         S_IDLE, S_ENTRY: begin
            if (is_digit) begin
               if (last_digit) begin
                  cnt_d   = 4'd0;
                  entry_d = '0;
                  if (entry_next == code_q) begin
                     state_d = S_OPEN;
                     fail_d  = 3'd0;
                     timer_d = OPEN_LOAD;
                  end else begin
                     state_d = S_IDLE;
                     fail_d  = fail_inc;
`ifdef LOCK_LOCKOUT_EN
                     if (fail_inc == FAIL_SAT) begin
                        state_d = S_LOCKOUT;
                        timer_d = LOCK_LOAD;
                     end
`endif
                  end
               end else begin
                  state_d = S_ENTRY;
                  cnt_d   = cnt_q + 4'd1;
                  entry_d = entry_next;
               end
            end else if (is_cancel && state_q == S_ENTRY) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
               entry_d = '0;
            end
         end
         S_OPEN: begin
            if (is_set) begin
               state_d  = S_PROG;
               timer_d  = 16'd0;
               cnt_d    = 4'd0;
               shadow_d = '0;
            end else if (timer_q <= 16'd1) begin
               state_d = S_IDLE;
               timer_d = 16'd0;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         S_PROG: begin
            if (is_digit) begin
               if (last_digit) begin
                  code_d   = shadow_next;
                  state_d  = S_IDLE;
                  cnt_d    = 4'd0;
                  shadow_d = '0;
               end else begin
                  cnt_d    = cnt_q + 4'd1;
                  shadow_d = shadow_next;
               end
            end else if (is_cancel) begin
               state_d  = S_IDLE;
               cnt_d    = 4'd0;
               shadow_d = '0;
            end
         end
`ifdef LOCK_LOCKOUT_EN
         S_LOCKOUT: begin
            if (timer_q <= 16'd1) begin
               state_d = S_IDLE;
               timer_d = 16'd0;
               fail_d  = 3'd0;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         code_q   <= '0;
         entry_q  <= '0;
         shadow_q <= '0;
         cnt_q    <= 4'd0;
         timer_q  <= 16'd0;
         fail_q   <= 3'd0;
         unlock_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         entry_q  <= entry_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         fail_q   <= fail_d;
         unlock_q <= (state_d == S_OPEN);
      end
   end

`ifdef LOCK_LOCKOUT_EN
   logic lockout_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lockout_q <= 1'b0;
      else        lockout_q <= (state_d == S_LOCKOUT);
   end
   assign lockout = lockout_q;
`else
   assign lockout = 1'b0;
`endif

   assign unlock   = unlock_q;
   assign fail_cnt = fail_q;
   assign state    = state_q;
endmodule

// File: tb/tb_code_lock_param.sv
// Bench for code_lock_param (default parameters): vector table plus
// hand-written reset, programming-cancel and lockout/saturation sequences.
module tb_code_lock_param;
  localparam logic [2:0] IDLE = 3'd0, ENTRY = 3'd1, OPEN = 3'd2, PROG = 3'd3, LOCK = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       unlock, lockout;
  logic [2:0] fail_cnt, state;

  code_lock_param #(
    .CODE_LEN(4), .OPEN_CYCLES(5), .MAX_TRIES(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .key_valid(key_valid), .key_code(key_code),
    .unlock(unlock), .lockout(lockout), .fail_cnt(fail_cnt), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

  // scoreboard: {state, unlock, lockout, fail_cnt}
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] pk(input logic [2:0] st, input logic un, input logic lo,
                                    input logic [2:0] fc);
    return {st, un, lo, fc};
  endfunction

  task automatic compare(input string name);
    logic [7:0] e, a;
    a = {state, unlock, lockout, fail_cnt};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected entry queued, got %h", name, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got state=%0d unlock=%0b lockout=%0b fail_cnt=%0d, want state=%0d unlock=%0b lockout=%0b fail_cnt=%0d",
                 name, a[7:5], a[4], a[3], a[2:0], e[7:5], e[4], e[3], e[2:0]);
      end
    end
  endtask

  // driver: one clock cycle per call, starting and ending on a falling edge
  task automatic step(input string name, input logic v, input logic [3:0] k, input logic e,
                      input logic [7:0] exp);
    exp_q.push_back(exp);
    key_valid = v;
    key_code  = k;
    ena       = e;
    @(negedge clk);
    key_valid = 1'b0;
    compare(name);
  endtask

  task automatic code4(input string name, input logic [15:0] c, input logic [7:0] fin,
                       input logic [2:0] fc_during);
    for (int i = 0; i < 3; i++)
      step(name, 1'b1, c[15-4*i -: 4], 1'b1, pk(ENTRY, 1'b0, 1'b0, fc_during));
    step(name, 1'b1, c[3:0], 1'b1, fin);
  endtask

  task automatic wait_open_close(input string name, input logic [2:0] fc);
    for (int i = 0; i < 4; i++) step(name, 1'b0, 4'd0, 1'b1, pk(OPEN, 1'b1, 1'b0, fc));
    step(name, 1'b0, 4'd0, 1'b1, pk(IDLE, 1'b0, 1'b0, fc));
  endtask

  task automatic pulse_reset(input string name);
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(pk(IDLE, 1'b0, 1'b0, 3'd0));
    compare(name);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [3:0] k;
    logic       e;
    logic [2:0] st;
    logic       un;
    logic [2:0] fc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [3:0] k, input logic e, input logic [2:0] st,
                     input logic un, input logic [2:0] fc);
    vec_t t;
    t.v = v; t.k = k; t.e = e; t.st = st; t.un = un; t.fc = fc;
    vecs.push_back(t);
  endtask

  initial begin
    // default code 0000 opens for exactly five cycles
    add(1, 4'h0, 1, ENTRY, 0, 0); add(1, 4'h0, 1, ENTRY, 0, 0);
    add(1, 4'h0, 1, ENTRY, 0, 0); add(1, 4'h0, 1, OPEN, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 4'h0, 1, OPEN, 1, 0);
    add(0, 4'h0, 1, IDLE, 0, 0);
    // open again and program 1234
    add(1, 4'h0, 1, ENTRY, 0, 0); add(1, 4'h0, 1, ENTRY, 0, 0);
    add(1, 4'h0, 1, ENTRY, 0, 0); add(1, 4'h0, 1, OPEN, 1, 0);
    add(1, 4'hE, 1, PROG, 0, 0);  add(1, 4'h1, 1, PROG, 0, 0);
    add(1, 4'h2, 1, PROG, 0, 0);  add(1, 4'h3, 1, PROG, 0, 0);
    add(1, 4'h4, 1, IDLE, 0, 0);
    // old code is now wrong
    add(1, 4'h0, 1, ENTRY, 0, 0); add(1, 4'h0, 1, ENTRY, 0, 0);
    add(1, 4'h0, 1, ENTRY, 0, 0); add(1, 4'h0, 1, IDLE, 0, 1);
    // new code opens and clears fail_cnt; digit/cancel do not alter the open time
    add(1, 4'h1, 1, ENTRY, 0, 1); add(1, 4'h2, 1, ENTRY, 0, 1);
    add(1, 4'h3, 1, ENTRY, 0, 1); add(1, 4'h4, 1, OPEN, 1, 0);
    add(1, 4'h7, 1, OPEN, 1, 0);  add(1, 4'hD, 1, OPEN, 1, 0);
    add(0, 4'h0, 1, OPEN, 1, 0);  add(0, 4'h0, 1, OPEN, 1, 0);
    add(0, 4'h0, 1, IDLE, 0, 0);
    // set/cancel/other codes outside their states are ignored
    add(1, 4'hE, 1, IDLE, 0, 0);  add(1, 4'hD, 1, IDLE, 0, 0);
    add(1, 4'hF, 1, IDLE, 0, 0);  add(1, 4'h1, 1, ENTRY, 0, 0);
    add(1, 4'hE, 1, ENTRY, 0, 0); add(1, 4'hA, 1, ENTRY, 0, 0);
    add(1, 4'hD, 1, IDLE, 0, 0);
    // ena low: keys have no effect
    add(1, 4'h1, 0, IDLE, 0, 0);  add(1, 4'h2, 0, IDLE, 0, 0);
    add(1, 4'h3, 0, IDLE, 0, 0);  add(1, 4'h4, 0, IDLE, 0, 0);

    // reset state
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.push_back(pk(IDLE, 1'b0, 1'b0, 3'd0));
    compare("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].v, vecs[i].k, vecs[i].e,
           pk(vecs[i].st, vecs[i].un, 1'b0, vecs[i].fc));

    // cancel during programming keeps code 1234
    code4("prog_cancel", 16'h1234, pk(OPEN, 1'b1, 1'b0, 3'd0), 3'd0);
    step("prog_cancel", 1'b1, 4'hE, 1'b1, pk(PROG, 1'b0, 1'b0, 3'd0));
    step("prog_cancel", 1'b1, 4'h5, 1'b1, pk(PROG, 1'b0, 1'b0, 3'd0));
    step("prog_cancel", 1'b1, 4'h6, 1'b1, pk(PROG, 1'b0, 1'b0, 3'd0));
    step("prog_cancel", 1'b1, 4'hD, 1'b1, pk(IDLE, 1'b0, 1'b0, 3'd0));
    code4("keep_code", 16'h1234, pk(OPEN, 1'b1, 1'b0, 3'd0), 3'd0);
    wait_open_close("keep_code", 3'd0);

    // reset mid-programming restores code 0000
    code4("rst_prog", 16'h1234, pk(OPEN, 1'b1, 1'b0, 3'd0), 3'd0);
    step("rst_prog", 1'b1, 4'hE, 1'b1, pk(PROG, 1'b0, 1'b0, 3'd0));
    step("rst_prog", 1'b1, 4'h5, 1'b1, pk(PROG, 1'b0, 1'b0, 3'd0));
    pulse_reset("rst_prog_now");
    code4("rst_prog_zero", 16'h0000, pk(OPEN, 1'b1, 1'b0, 3'd0), 3'd0);
    wait_open_close("rst_prog_zero", 3'd0);

    // reset mid-entry with a nonzero fail count
    code4("rst_entry", 16'h9999, pk(IDLE, 1'b0, 1'b0, 3'd1), 3'd0);
    step("rst_entry", 1'b1, 4'h0, 1'b1, pk(ENTRY, 1'b0, 1'b0, 3'd1));
    step("rst_entry", 1'b1, 4'h0, 1'b1, pk(ENTRY, 1'b0, 1'b0, 3'd1));
    pulse_reset("rst_entry_now");
    code4("rst_entry_open", 16'h0000, pk(OPEN, 1'b1, 1'b0, 3'd0), 3'd0);
    wait_open_close("rst_entry_open", 3'd0);

`ifdef LOCK_LOCKOUT_EN
    code4("lock_w1", 16'h9999, pk(IDLE, 1'b0, 1'b0, 3'd1), 3'd0);
    code4("lock_w2", 16'h9999, pk(IDLE, 1'b0, 1'b0, 3'd2), 3'd1);
    code4("lock_w3", 16'h9999, pk(LOCK, 1'b0, 1'b1, 3'd3), 3'd2);
    for (int i = 0; i < 15; i++)
      step("lock_hold", 1'b1, (i % 5 == 4) ? 4'hD : 4'h0, 1'b1, pk(LOCK, 1'b0, 1'b1, 3'd3));
    step("lock_end", 1'b0, 4'h0, 1'b1, pk(IDLE, 1'b0, 1'b0, 3'd0));
`else
    for (int i = 0; i < 8; i++)
      code4($sformatf("sat_w%0d", i + 1), 16'h9999,
            pk(IDLE, 1'b0, 1'b0, (i >= 6) ? 3'd7 : 3'(i + 1)), (i >= 7) ? 3'd7 : 3'(i));
`endif
    code4("after_fail", 16'h0000, pk(OPEN, 1'b1, 1'b0, 3'd0),
`ifdef LOCK_LOCKOUT_EN
          3'd0);
`else
          3'd7);
`endif
    wait_open_close("after_fail", 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/code_lock_param.md
CODE_LOCK_PARAM -- requirements
Module: code_lock_param

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4: passcode length in digits, legal 1..8.
REQ-002 SHALL have parameter OPEN_CYCLES, default 5: clock cycles spent in OPEN before auto-relock, legal 1..255.
REQ-003 SHALL have parameter MAX_TRIES, default 3: wrong complete codes that trigger lockout, legal 1..7.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 16: lockout duration in clock cycles, legal 1..65535.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port ena, input, 1 bit: when low, key_valid is ignored and timers keep running.
REQ-008 SHALL have port key_valid, input, 1 bit: qualifies key_code for exactly one cycle.
REQ-009 SHALL have port key_code, input, 4 bits: 0x0-0x9 digit, 0xD cancel, 0xE set-passcode, all other codes ignored.
REQ-010 SHALL have port unlock, output, 1 bit: high while in OPEN.
REQ-011 SHALL have port lockout, output, 1 bit: high while in LOCKOUT.
REQ-012 SHALL have port fail_cnt, output, 3 bits: consecutive wrong codes.
REQ-013 SHALL have port state, output, 3 bits: IDLE=0, ENTRY=1, OPEN=2, PROG=3, LOCKOUT=4.

Function
REQ-014 All outputs SHALL be registered; a key takes effect on the cycle after the edge that samples it.
REQ-015 IDLE/ENTRY SHALL count every digit and store it in an entry buffer; no match/mismatch is indicated before CODE_LEN digits.
REQ-016 When digit CODE_LEN arrives and the whole buffer equals the stored code, the block SHALL enter OPEN, clear fail_cnt, and load the open timer with OPEN_CYCLES.
REQ-017 On a mismatch, the block SHALL increment fail_cnt and return to IDLE; if the incremented value equals MAX_TRIES it SHALL instead enter LOCKOUT.
REQ-018 Cancel in ENTRY SHALL return to IDLE, clear the digit count, and leave fail_cnt unchanged.
REQ-019 OPEN SHALL decrement its timer every cycle and go to IDLE at zero; digits and cancel SHALL neither extend nor shorten OPEN.
REQ-020 Set-passcode in OPEN SHALL enter PROG and stop the open timer; unlock SHALL stay low during PROG.
REQ-021 PROG SHALL collect CODE_LEN digits into a shadow buffer and commit all of them to the stored code atomically on the last digit, then go to IDLE.
REQ-022 Cancel in PROG SHALL discard the shadow buffer, keep the old code, and go to IDLE; non-digit keys in PROG SHALL be ignored.
REQ-023 LOCKOUT SHALL ignore all keys, including cancel, for LOCKOUT_CYCLES cycles, then go to IDLE with fail_cnt cleared.
REQ-024 Set-passcode outside OPEN SHALL be ignored.
REQ-025 fail_cnt SHALL saturate at MAX_TRIES.

Reset
REQ-026 While rst_n is low: state=IDLE, unlock=0, lockout=0, fail_cnt=0, all counters and buffers 0, and the stored code all 0x0 digits.
REQ-027 Reset asserted mid-PROG or mid-LOCKOUT SHALL take effect immediately, restore the all-zero code, and discard any partial entry.

Configuration
REQ-028 Macro LOCK_LOCKOUT_EN SHALL compile in the lockout feature (LOCKOUT state, lockout timer, MAX_TRIES check).
REQ-029 Without LOCK_LOCKOUT_EN: a mismatch SHALL always return to IDLE, fail_cnt SHALL still count and saturate at 7, and lockout SHALL be tied to 0.

Verification
REQ-030 After reset, keys 0,0,0,0 -> unlock=1 one cycle after the 4th key, held exactly 5 cycles, then state=IDLE.
REQ-031 While OPEN: keys E,1,2,3,4 -> stored code becomes 1234; then 0,0,0,0 -> fail_cnt=1, unlock=0; then 1,2,3,4 -> unlock=1 and fail_cnt=0.
REQ-032 Three wrong codes (9,9,9,9 x3) -> lockout=1 for 16 cycles with keys 0,0,0,0 ignored throughout, then IDLE with fail_cnt=0.
REQ-033 While OPEN: keys E,5,6 then D -> stored code unchanged (0000), state=IDLE.
REQ-034 After keys 0,0 in ENTRY, assert rst_n low for 1 cycle -> all outputs at reset values; then 0,0,0,0 -> unlock=1.
REQ-035 With ena=0, key sequence 0,0,0,0 -> no state change; with LOCK_LOCKOUT_EN undefined, 8 wrong codes -> fail_cnt=7 and lockout=0.
